// File: rtl/watch_pkg.sv
// Shared watch constants: time base and button FSM state codes.
// Imported by button_conditioner, ms_tick_gen and the watch FSM.
package watch_pkg;

    localparam int MS_PER_SEC       = 1000;
    localparam int CLK_FREQ_DEFAULT = 100_000_000;

    localparam logic [1:0] BTN_IDLE   = 2'd0;
    localparam logic [1:0] BTN_HOLD   = 2'd1;
    localparam logic [1:0] BTN_REPEAT = 2'd2;

endpackage

// File: rtl/ms_tick_gen.sv
// 1 ms time base: one-cycle ms_tick at the prescaler terminal count.
// Ports: clk, reset_n (sync, active-low) in; ms_tick out.
module ms_tick_gen
    import watch_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    output logic ms_tick
);

    localparam int DIV_RAW = CLK_FREQ / MS_PER_SEC;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int W       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TC = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign ms_tick = (cnt == TC);

endmodule

// File: rtl/button_conditioner.sv
// Button front end: 2-FF sync, ms debounce, press/release ticks.
// Ports: clk, reset_n, btn_in in; btn_level, press_tick,
// release_tick, long_press out. Define AUTO_REPEAT_EN for
// hold-to-repeat; otherwise press_tick is edge-only and
// long_press is tied low.
module button_conditioner
    import watch_pkg::*;
#(
    parameter int CLK_FREQ    = CLK_FREQ_DEFAULT,
    parameter int N_BTN       = 4,
    parameter int DEBOUNCE_MS = 10,
    parameter int HOLD_MS     = 500,
    parameter int REPEAT_MS   = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_tick,
    output logic [N_BTN-1:0] release_tick,
    output logic [N_BTN-1:0] long_press
);

    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_MS);

    if (DEBOUNCE_MS < 1 || HOLD_MS < 1 || REPEAT_MS < 1)
    begin : g_bad_param
        $error("button_conditioner: ms parameters must be >= 1");
    end

    logic ms_tick;

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_ms_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .ms_tick (ms_tick)
    );

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch

        logic            sync_q1;
        logic            sync_q2;
        logic            level;
        logic            level_d;
        logic            edge_press;
        logic            edge_rel;
        logic            rise;
        logic            fall;
        logic [DB_W-1:0] db_cnt;
        logic [DB_W-1:0] db_nxt;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sync_q1 <= 1'b0;
                sync_q2 <= 1'b0;
            end else begin
                sync_q1 <= btn_in[i];
                sync_q2 <= sync_q1;
            end
        end

        assign db_nxt = db_cnt + 1'b1;

        // Counter only advances while the synced input disagrees
        // with the accepted level; any agreement restarts it.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                db_cnt <= '0;
                level  <= 1'b0;
            end else if (sync_q2 == level) begin
                db_cnt <= '0;
            end else if (ms_tick) begin
                if (db_nxt == DB_TC) begin
                    level  <= sync_q2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_nxt;
                end
            end
        end

        assign rise = level & ~level_d;
        assign fall = ~level & level_d;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                level_d    <= 1'b0;
                edge_press <= 1'b0;
                edge_rel   <= 1'b0;
            end else begin
                level_d    <= level;
                edge_press <= rise;
                edge_rel   <= fall;
            end
        end

        assign btn_level[i]    = level;
        assign release_tick[i] = edge_rel;

`ifdef AUTO_REPEAT_EN
        localparam int RP_MAX =
            (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
        localparam int RP_W = $clog2(RP_MAX + 1);
        localparam logic [RP_W-1:0] HOLD_TC = RP_W'(HOLD_MS);
        localparam logic [RP_W-1:0] REP_TC  = RP_W'(REPEAT_MS);

        logic [1:0]      state;
        logic [RP_W-1:0] hold_cnt;
        logic [RP_W-1:0] hold_nxt;
        logic            rpt_q;
        logic            long_q;

        assign hold_nxt = hold_cnt + 1'b1;

        // A fall always wins, so an expiry coinciding with the
        // release never produces a repeat tick.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state    <= BTN_IDLE;
                hold_cnt <= '0;
                rpt_q    <= 1'b0;
                long_q   <= 1'b0;
            end else begin
                rpt_q <= 1'b0;
                if (fall) begin
                    state    <= BTN_IDLE;
                    hold_cnt <= '0;
                    long_q   <= 1'b0;
                end else begin
                    unique case (state)
                        BTN_IDLE: begin
                            if (rise) begin
                                state    <= BTN_HOLD;
                                hold_cnt <= '0;
                            end
                        end
                        BTN_HOLD: begin
                            if (ms_tick) begin
                                if (hold_nxt == HOLD_TC) begin
                                    state    <= BTN_REPEAT;
                                    hold_cnt <= '0;
                                    rpt_q    <= 1'b1;
                                    long_q   <= 1'b1;
                                end else begin
                                    hold_cnt <= hold_nxt;
                                end
                            end
                        end
                        BTN_REPEAT: begin
                            if (ms_tick) begin
                                if (hold_nxt == REP_TC) begin
                                    hold_cnt <= '0;
                                    rpt_q    <= 1'b1;
                                end else begin
                                    hold_cnt <= hold_nxt;
                                end
                            end
                        end
                        default: begin
                            state    <= BTN_IDLE;
                            hold_cnt <= '0;
                            long_q   <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign press_tick[i] = edge_press | rpt_q;
        assign long_press[i] = long_q;
`else
        assign press_tick[i] = edge_press;
        assign long_press[i] = 1'b0;
`endif

    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: cycle model plus directed checks.
// Small sim parameters: 1 ms = 10 clk.
module tb_button_conditioner;

    localparam int CLK_FREQ = 10_000;
    localparam int N        = 2;
    localparam int DB       = 2;
    localparam int HOLD     = 5;
    localparam int REP      = 2;
    localparam int DIV      = CLK_FREQ / 1000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] press_tick;
    logic [N-1:0] release_tick;
    logic [N-1:0] long_press;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .CLK_FREQ    (CLK_FREQ),
        .N_BTN       (N),
        .DEBOUNCE_MS (DB),
        .HOLD_MS     (HOLD),
        .REPEAT_MS   (REP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_tick   (press_tick),
        .release_tick (release_tick),
        .long_press   (long_press)
    );

    // Reference model state: the synced input, the accepted level,
    // how many ms boundaries a disagreement has lasted, and how many
    // ms have elapsed since the press was reported.
    logic [N-1:0] m_s1, m_s2, m_lv, m_lvd;
    logic [N-1:0] m_press, m_rel, m_long;
    int           m_k;
    int           m_mism [N];
    int           m_held [N];
    bit           m_act  [N];

    int cyc_n = 0;
    int pq0[$], pq1[$], rq0[$], rq1[$], lr0[$], lf0[$];
    logic prev_long0 = 1'b0;

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic int at(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic model_edge();
        bit tick;
        bit rise, fall, rp;
        if (!reset_n) begin
            m_k = 0;
            m_s1 = '0; m_s2 = '0; m_lv = '0; m_lvd = '0;
            m_press = '0; m_rel = '0; m_long = '0;
            for (int c = 0; c < N; c++) begin
                m_mism[c] = 0; m_held[c] = 0; m_act[c] = 0;
            end
            return;
        end
        tick = ((m_k % DIV) == DIV - 1);
        m_k++;
        for (int c = 0; c < N; c++) begin
            rise = m_lv[c] & ~m_lvd[c];
            fall = ~m_lv[c] & m_lvd[c];
            rp = 0;
`ifdef AUTO_REPEAT_EN
            if (fall) begin
                m_act[c] = 0;
                m_long[c] = 0;
            end else if (rise) begin
                m_act[c] = 1;
                m_held[c] = 0;
            end else if (m_act[c] && tick) begin
                m_held[c]++;
                if (m_held[c] == HOLD ||
                    (m_held[c] > HOLD &&
                     (m_held[c] - HOLD) % REP == 0)) begin
                    rp = 1;
                    m_long[c] = 1;
                end
            end
`endif
            m_press[c] = rise | rp;
            m_rel[c] = fall;
            m_lvd[c] = m_lv[c];
            if (m_s2[c] == m_lv[c]) begin
                m_mism[c] = 0;
            end else if (tick) begin
                m_mism[c]++;
                if (m_mism[c] == DB) begin
                    m_lv[c] = m_s2[c];
                    m_mism[c] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
    endtask

    task automatic cyc();
        model_edge();
        @(negedge clk);
        cyc_n++;
        chk("level", btn_level, m_lv);
        chk("press", press_tick, m_press);
        chk("release", release_tick, m_rel);
        chk("long", long_press, m_long);
        if (press_tick[0]) pq0.push_back(cyc_n);
        if (press_tick[1]) pq1.push_back(cyc_n);
        if (release_tick[0]) rq0.push_back(cyc_n);
        if (release_tick[1]) rq1.push_back(cyc_n);
        if (long_press[0] && !prev_long0) lr0.push_back(cyc_n);
        if (!long_press[0] && prev_long0) lf0.push_back(cyc_n);
        prev_long0 = long_press[0];
    endtask

    task automatic clr();
        pq0.delete(); pq1.delete(); rq0.delete();
        rq1.delete(); lr0.delete(); lf0.delete();
    endtask

    task automatic run(int n);
        repeat (n) cyc();
    endtask

    int base;
    int t;

    initial begin
        @(negedge clk);
        // 1: reset with buttons held, then release
        btn_in = 2'b11;
        reset_n = 1'b0;
        run(5);
        chk("rst_out", {btn_level, press_tick,
                        release_tick, long_press}, 0);
        reset_n = 1'b1;
        clr();
        base = cyc_n;
        run(40);
        chk("t1_np0", pq0.size(), 1);
        chk("t1_np1", pq1.size(), 1);
        t = at(pq0, 0) - base;
        chk("t1_win0", (t >= 21 && t <= 31), 1);
        t = at(pq1, 0) - base;
        chk("t1_win1", (t >= 21 && t <= 31), 1);
        btn_in = 2'b00;
        run(60);

        // 2: bouncing press, then short pulse on idle line
        clr();
        btn_in[0] = 1'b1; run(5);
        btn_in[0] = 1'b0; run(5);
        btn_in[0] = 1'b1; run(40);
        chk("t2_bounce_np", pq0.size(), 1);
        btn_in[0] = 1'b0;
        run(60);
        t = 0;
        while (m_k % DIV != 8 && t < 2 * DIV) begin
            cyc(); t++;
        end
        clr();
        btn_in[0] = 1'b1; run(15);
        btn_in[0] = 1'b0; run(40);
        chk("t2_glitch_np", pq0.size(), 0);
        chk("t2_glitch_nr", rq0.size(), 0);

        // random activity, model-checked every cycle
        for (int s = 0; s < 40; s++) begin
            btn_in = N'($urandom_range(0, 3));
            run($urandom_range(1, 60));
        end
        btn_in = '0;
        run(80);

`ifdef AUTO_REPEAT_EN
        // 3+4: hold ch0, repeat schedule, then release
        clr();
        btn_in[0] = 1'b1;
        t = 0;
        while (pq0.size() == 0 && t < 60) begin
            cyc(); t++;
        end
        chk("t3_first", pq0.size(), 1);
        run(106);
        btn_in[0] = 1'b0;
        run(50);
        chk("t3_np", pq0.size(), 5);
        chk("t3_gap1", at(pq0, 1) - at(pq0, 0), 49);
        chk("t3_gap2", at(pq0, 2) - at(pq0, 1), 20);
        chk("t3_gap3", at(pq0, 3) - at(pq0, 2), 20);
        chk("t3_gap4", at(pq0, 4) - at(pq0, 3), 20);
        chk("t3_long_rise", at(lr0, 0), at(pq0, 1));
        chk("t4_nr", rq0.size(), 1);
        chk("t4_rel_lat", at(rq0, 0) - at(pq0, 4), 11);
        chk("t4_long_fall", at(lf0, 0), at(rq0, 0));

        // 5: both pressed together, ch1 released early
        clr();
        btn_in = 2'b11;
        for (int i = 1; i <= 180; i++) begin
            cyc();
            if (i == 30) btn_in[1] = 1'b0;
            if (pq0.size() > 0 && cyc_n == pq0[0] + 106)
                btn_in[0] = 1'b0;
        end
        chk("t5_np0", pq0.size(), 5);
        chk("t5_gap1", at(pq0, 1) - at(pq0, 0), 49);
        chk("t5_gap4", at(pq0, 4) - at(pq0, 3), 20);
        chk("t5_np1", pq1.size(), 1);
        chk("t5_same", at(pq1, 0), at(pq0, 0));
        chk("t5_nr1", rq1.size(), 1);
        chk("t5_nr0", rq0.size(), 1);
        run(40);
`endif

        // 6: reset while held, then fresh press
        clr();
        btn_in = 2'b01;
`ifdef AUTO_REPEAT_EN
        t = 0;
        while (!long_press[0] && t < 150) begin
            cyc(); t++;
        end
        chk("t6_in_repeat", long_press[0], 1);
`else
        run(60);
        chk("t6_pressed", btn_level[0], 1);
`endif
        reset_n = 1'b0;
        cyc();
        chk("t6_rst_out", {btn_level, press_tick,
                           release_tick, long_press}, 0);
        reset_n = 1'b1;
        clr();
        run(40);
        chk("t6_fresh_np", pq0.size(), 1);
        chk("t6_no_rel", rq0.size(), 0);
        btn_in = '0;
        run(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
